// File: rtl/apb_master_bridge.sv
// apb_master_bridge: turns a valid/ready command channel into single APB
// transfers and returns read data and error status on a held response channel.
// A wait-state counter aborts an ACCESS phase that never sees pready.
module apb_master_bridge #(
  parameter int TIMEOUT = 16
) (
  input  logic        pclk,
  input  logic        presetn,
  // command channel
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  // response channel
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        rsp_timeout,
  // APB requester side
  output logic        psel,
  output logic        penable,
  output logic        pwrite,
  output logic [31:0] paddr,
  output logic [31:0] pwdata,
  input  logic [31:0] prdata,
  input  logic        pready,
  input  logic        pslverr
);

  // Counter is wide enough to hold TIMEOUT itself; a disabled timeout
  // still keeps a 1-bit counter so the datapath stays uniform.
  localparam int            CW     = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam bit            TMO_EN = (TIMEOUT != 0);
  localparam logic [CW-1:0] TO_VAL = CW'(TIMEOUT);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  state_t        r_state;
  logic          r_cmd_ready;
  logic          r_psel;
  logic          r_penable;
  logic          r_pwrite;
  logic [31:0]   r_paddr;
  logic [31:0]   r_pwdata;
  logic          r_rsp_valid;
  logic [31:0]   r_rsp_rdata;
  logic          r_rsp_err;
  logic          r_rsp_timeout;
  logic [CW-1:0] r_wait_cnt;

  logic          w_accept;
  logic          w_complete;
  logic          w_abort;
  logic          w_release;

  // Handshake qualifiers. pready only matters in ACCESS; a completion on the
  // same edge the counter hits its limit takes priority over the abort.
  assign w_accept   = (r_state == ST_IDLE) && cmd_valid && r_cmd_ready;
  assign w_complete = (r_state == ST_ACCESS) && pready;
  assign w_abort    = (r_state == ST_ACCESS) && !pready && TMO_EN &&
                      (r_wait_cnt == TO_VAL);
  assign w_release  = (r_state == ST_RESP) && rsp_ready;

  // Phase sequencer with all bus and response outputs registered.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      r_state       <= ST_IDLE;
      r_cmd_ready   <= 1'b1;
      r_psel        <= 1'b0;
      r_penable     <= 1'b0;
      r_pwrite      <= 1'b0;
      r_paddr       <= '0;
      r_pwdata      <= '0;
      r_rsp_valid   <= 1'b0;
      r_rsp_rdata   <= '0;
      r_rsp_err     <= 1'b0;
      r_rsp_timeout <= 1'b0;
      r_wait_cnt    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_state     <= ST_SETUP;
            r_cmd_ready <= 1'b0;
            r_psel      <= 1'b1;
            r_penable   <= 1'b0;
            r_pwrite    <= cmd_write;
            r_paddr     <= cmd_addr;
            // pwdata is forced to zero for reads so the bus never carries
            // stale or unrelated write data.
            r_pwdata    <= cmd_write ? cmd_wdata : '0;
          end
        end

        ST_SETUP: begin
          r_state    <= ST_ACCESS;
          r_penable  <= 1'b1;
          r_wait_cnt <= '0;
        end

        ST_ACCESS: begin
          if (w_complete) begin
            r_state       <= ST_RESP;
            r_psel        <= 1'b0;
            r_penable     <= 1'b0;
            r_rsp_valid   <= 1'b1;
            // prdata is only looked at for reads, so Z/X on writes is dropped.
            r_rsp_rdata   <= r_pwrite ? 32'h0 : prdata;
            r_rsp_err     <= pslverr;
            r_rsp_timeout <= 1'b0;
          end else if (w_abort) begin
            r_state       <= ST_RESP;
            r_psel        <= 1'b0;
            r_penable     <= 1'b0;
            r_rsp_valid   <= 1'b1;
            r_rsp_rdata   <= 32'h0;
            r_rsp_err     <= 1'b1;
            r_rsp_timeout <= 1'b1;
          end else if (TMO_EN) begin
            r_wait_cnt <= r_wait_cnt + CW'(1);
          end
        end

        ST_RESP: begin
          if (w_release) begin
            r_state       <= ST_IDLE;
            r_cmd_ready   <= 1'b1;
            r_rsp_valid   <= 1'b0;
            r_rsp_rdata   <= 32'h0;
            r_rsp_err     <= 1'b0;
            r_rsp_timeout <= 1'b0;
          end
        end

        default: begin
          r_state     <= ST_IDLE;
          r_cmd_ready <= 1'b1;
          r_psel      <= 1'b0;
          r_penable   <= 1'b0;
          r_rsp_valid <= 1'b0;
        end
      endcase
    end
  end

  assign cmd_ready   = r_cmd_ready;
  assign psel        = r_psel;
  assign penable     = r_penable;
  assign pwrite      = r_pwrite;
  assign paddr       = r_paddr;
  assign pwdata      = r_pwdata;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_rdata   = r_rsp_rdata;
  assign rsp_err     = r_rsp_err;
  assign rsp_timeout = r_rsp_timeout;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Bench for apb_master_bridge: drives commands and a scripted APB completer,
// checks bus timing inline and response contents through a scoreboard queue.
module tb_apb_master_bridge;

  logic        pclk = 1'b0;
  logic        presetn;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        rsp_timeout;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
    logic        tmo;
  } rsp_t;

  rsp_t exp_q[$];
  rsp_t mon_e;
  int   total = 0;
  int   bad   = 0;

  apb_master_bridge #(.TIMEOUT(4)) dut (
    .pclk        (pclk),
    .presetn     (presetn),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_write   (cmd_write),
    .cmd_addr    (cmd_addr),
    .cmd_wdata   (cmd_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_rdata   (rsp_rdata),
    .rsp_err     (rsp_err),
    .rsp_timeout (rsp_timeout),
    .psel        (psel),
    .penable     (penable),
    .pwrite      (pwrite),
    .paddr       (paddr),
    .pwdata      (pwdata),
    .prdata      (prdata),
    .pready      (pready),
    .pslverr     (pslverr)
  );

  always #5 pclk = ~pclk;

  // Scoreboard: every response handshake pops the oldest expectation.
  always @(negedge pclk) begin
    if (presetn === 1'b1 && rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_rsp: got rdata=%h err=%b tmo=%b, required no response",
                 rsp_rdata, rsp_err, rsp_timeout);
      end else begin
        mon_e = exp_q.pop_front();
        total++;
        if (rsp_rdata !== mon_e.rdata) begin
          bad++;
          $display("FAIL rsp_rdata: got %h required %h", rsp_rdata, mon_e.rdata);
        end
        total++;
        if (rsp_err !== mon_e.err) begin
          bad++;
          $display("FAIL rsp_err: got %b required %b", rsp_err, mon_e.err);
        end
        total++;
        if (rsp_timeout !== mon_e.tmo) begin
          bad++;
          $display("FAIL rsp_timeout: got %b required %b", rsp_timeout, mon_e.tmo);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1, "watchdog expired");
  end

  // Present a command until it is accepted; returns one cycle after acceptance.
  task automatic issue_cmd(input logic wr, input logic [31:0] a, input logic [31:0] d);
    logic acc;
    bit   ok;
    ok        = 1'b0;
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = a;
    cmd_wdata = d;
    for (int n = 0; n < 20; n++) begin
      acc = cmd_ready;
      @(posedge pclk); #1;
      if (acc === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    cmd_valid = 1'b0;
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL cmd_accept: got not accepted required accepted within 20 cycles");
    end
  endtask

  // Completer model: called in the SETUP cycle, answers after nwait wait
  // states (never when hang), returns the number of ACCESS cycles seen.
  task automatic run_access(input int nwait, input bit hang, input logic err,
                            input logic [31:0] rd, output int n);
    pready = 1'b0;
    @(posedge pclk); #1;
    n = 0;
    while (psel === 1'b1 && penable === 1'b1 && n < 40) begin
      if (!hang && n == nwait) begin
        pready  = 1'b1;
        prdata  = rd;
        pslverr = err;
      end else begin
        pready  = 1'b0;
        prdata  = 'z;
        pslverr = 1'bx;
      end
      @(posedge pclk); #1;
      n++;
    end
    pready  = 1'b0;
    prdata  = 'z;
    pslverr = 1'bx;
  endtask

  // Wait for a response (bounded) and consume it.
  task automatic drain_rsp();
    int n;
    n = 0;
    while (rsp_valid !== 1'b1 && n < 20) begin
      @(posedge pclk); #1;
      n++;
    end
    total++;
    if (rsp_valid !== 1'b1) begin
      bad++;
      $display("FAIL rsp_wait: got rsp_valid=%b required 1 within 20 cycles", rsp_valid);
    end
    rsp_ready = 1'b1;
    @(posedge pclk); #1;
    rsp_ready = 1'b0;
    total++;
    if (rsp_valid !== 1'b0) begin
      bad++;
      $display("FAIL rsp_clear: got rsp_valid=%b required 0", rsp_valid);
    end
  endtask

  task automatic test_reset();
    presetn   = 1'b0;
    cmd_valid = 1'($urandom_range(0, 1));
    cmd_write = 1'($urandom_range(0, 1));
    cmd_addr  = $urandom;
    cmd_wdata = $urandom;
    rsp_ready = 1'($urandom_range(0, 1));
    prdata    = $urandom;
    pready    = 1'($urandom_range(0, 1));
    pslverr   = 1'($urandom_range(0, 1));
    repeat (3) @(posedge pclk);
    #1;
    total++;
    if ({psel, penable, pwrite} !== 3'b000) begin
      bad++;
      $display("FAIL reset_bus_ctl: got psel/penable/pwrite=%b required 000", {psel, penable, pwrite});
    end
    total++;
    if (paddr !== 32'h0 || pwdata !== 32'h0) begin
      bad++;
      $display("FAIL reset_bus_data: got paddr=%h pwdata=%h required 0/0", paddr, pwdata);
    end
    total++;
    if ({rsp_valid, rsp_err, rsp_timeout} !== 3'b000 || rsp_rdata !== 32'h0) begin
      bad++;
      $display("FAIL reset_rsp: got v/e/t=%b rdata=%h required 000/0",
               {rsp_valid, rsp_err, rsp_timeout}, rsp_rdata);
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b0;
    pready    = 1'b0;
    prdata    = 'z;
    pslverr   = 1'bx;
    presetn   = 1'b1;
    @(posedge pclk); #1;
    total++;
    if (cmd_ready !== 1'b1 || psel !== 1'b0) begin
      bad++;
      $display("FAIL reset_release: got cmd_ready=%b psel=%b required 1/0", cmd_ready, psel);
    end
  endtask

  task automatic test_write_zero_wait();
    rsp_t t;
    t.rdata = 32'h0; t.err = 1'b0; t.tmo = 1'b0;
    exp_q.push_back(t);
    issue_cmd(1'b1, 32'h0000_0010, 32'hDEAD_BEEF);
    // cycle 1: SETUP
    total++;
    if ({psel, penable} !== 2'b10) begin
      bad++;
      $display("FAIL wr_setup: got psel/penable=%b required 10", {psel, penable});
    end
    @(posedge pclk); #1;
    // cycle 2: ACCESS
    total++;
    if ({psel, penable, pwrite} !== 3'b111 || paddr !== 32'h10 || pwdata !== 32'hDEAD_BEEF) begin
      bad++;
      $display("FAIL wr_access: got sel/en/wr=%b paddr=%h pwdata=%h required 111/10/deadbeef",
               {psel, penable, pwrite}, paddr, pwdata);
    end
    pready  = 1'b1;
    pslverr = 1'b0;
    prdata  = 'x;
    @(posedge pclk); #1;
    // cycle 3: response
    pready  = 1'b0;
    prdata  = 'z;
    pslverr = 1'bx;
    total++;
    if (rsp_valid !== 1'b1 || psel !== 1'b0) begin
      bad++;
      $display("FAIL wr_rsp_timing: got rsp_valid=%b psel=%b required 1/0", rsp_valid, psel);
    end
    rsp_ready = 1'b1;
    @(posedge pclk); #1;
    rsp_ready = 1'b0;
    // cycle 4: ready for the next command
    total++;
    if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      bad++;
      $display("FAIL wr_turnaround: got cmd_ready=%b rsp_valid=%b required 1/0", cmd_ready, rsp_valid);
    end
  endtask

  task automatic test_read_wait3();
    rsp_t t;
    int   n;
    t.rdata = 32'hDEAD_BEEF; t.err = 1'b0; t.tmo = 1'b0;
    exp_q.push_back(t);
    issue_cmd(1'b0, 32'h0000_0010, 32'hFFFF_0000);
    total++;
    if (pwdata !== 32'h0 || pwrite !== 1'b0 || paddr !== 32'h10) begin
      bad++;
      $display("FAIL rd_setup: got pwdata=%h pwrite=%b paddr=%h required 0/0/10", pwdata, pwrite, paddr);
    end
    run_access(3, 1'b0, 1'b0, 32'hDEAD_BEEF, n);
    total++;
    if (n !== 4) begin
      bad++;
      $display("FAIL rd_access_len: got %0d cycles required 4", n);
    end
    @(posedge pclk); #1;
    total++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hDEAD_BEEF) begin
      bad++;
      $display("FAIL rd_hold: got rsp_valid=%b rdata=%h required 1/deadbeef", rsp_valid, rsp_rdata);
    end
    drain_rsp();
  endtask

  task automatic test_slverr();
    rsp_t t;
    int   n;
    t.rdata = 32'h0BAD_0BAD; t.err = 1'b1; t.tmo = 1'b0;
    exp_q.push_back(t);
    issue_cmd(1'b0, 32'h0000_0020, 32'h0);
    run_access(1, 1'b0, 1'b1, 32'h0BAD_0BAD, n);
    total++;
    if (n !== 2) begin
      bad++;
      $display("FAIL err_access_len: got %0d cycles required 2", n);
    end
    for (int i = 0; i < 3; i++) begin
      total++;
      if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_timeout !== 1'b0) begin
        bad++;
        $display("FAIL err_hold: got v/e/t=%b required 110", {rsp_valid, rsp_err, rsp_timeout});
      end
      @(posedge pclk); #1;
    end
    drain_rsp();
  endtask

  task automatic test_timeout();
    rsp_t t;
    int   n;
    t.rdata = 32'h0; t.err = 1'b1; t.tmo = 1'b1;
    exp_q.push_back(t);
    issue_cmd(1'b0, 32'h0000_0030, 32'h0);
    run_access(0, 1'b1, 1'b0, 32'h0, n);
    total++;
    if (n !== 5) begin
      bad++;
      $display("FAIL tmo_access_len: got %0d cycles required 5", n);
    end
    total++;
    if (psel !== 1'b0 || rsp_valid !== 1'b1 || rsp_timeout !== 1'b1) begin
      bad++;
      $display("FAIL tmo_rsp: got psel=%b rsp_valid=%b rsp_timeout=%b required 0/1/1",
               psel, rsp_valid, rsp_timeout);
    end
    drain_rsp();
  endtask

  task automatic test_backpressure();
    rsp_t t;
    int   n;
    t.rdata = 32'h0; t.err = 1'b0; t.tmo = 1'b0;
    exp_q.push_back(t);
    issue_cmd(1'b1, 32'h0000_0040, 32'h1111_2222);
    run_access(0, 1'b0, 1'b0, 32'h0, n);
    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    cmd_addr  = 32'h0000_0044;
    cmd_wdata = 32'h5555_AAAA;
    for (int i = 0; i < 10; i++) begin
      total++;
      if (cmd_ready !== 1'b0 || psel !== 1'b0 || rsp_valid !== 1'b1) begin
        bad++;
        $display("FAIL bp_stall: got cmd_ready=%b psel=%b rsp_valid=%b required 0/0/1",
                 cmd_ready, psel, rsp_valid);
      end
      @(posedge pclk); #1;
    end
    rsp_ready = 1'b1;
    @(posedge pclk); #1;
    rsp_ready = 1'b0;
    total++;
    if (cmd_ready !== 1'b1 || psel !== 1'b0) begin
      bad++;
      $display("FAIL bp_release: got cmd_ready=%b psel=%b required 1/0", cmd_ready, psel);
    end
    exp_q.push_back(t);
    issue_cmd(1'b1, 32'h0000_0044, 32'h5555_AAAA);
    total++;
    if (psel !== 1'b1 || paddr !== 32'h44) begin
      bad++;
      $display("FAIL bp_held_cmd: got psel=%b paddr=%h required 1/44", psel, paddr);
    end
    run_access(0, 1'b0, 1'b0, 32'h0, n);
    drain_rsp();
  endtask

  task automatic test_back_to_back();
    rsp_t        t;
    int          n;
    int          w;
    logic        wr;
    logic        e;
    logic [31:0] rd;
    for (int i = 0; i < 4; i++) begin
      wr = 1'($urandom_range(0, 1));
      e  = 1'($urandom_range(0, 1));
      rd = $urandom;
      w  = int'($urandom_range(0, 2));
      t.rdata = wr ? 32'h0 : rd;
      t.err   = e;
      t.tmo   = 1'b0;
      exp_q.push_back(t);
      issue_cmd(wr, $urandom, $urandom);
      run_access(w, 1'b0, e, rd, n);
      total++;
      if (n !== w + 1) begin
        bad++;
        $display("FAIL b2b_access_len: got %0d cycles required %0d", n, w + 1);
      end
      drain_rsp();
    end
  endtask

  task automatic test_reset_mid();
    issue_cmd(1'b1, 32'h0000_0050, 32'hCAFE_F00D);
    pready = 1'b0;
    @(posedge pclk); #1;
    total++;
    if ({psel, penable} !== 2'b11) begin
      bad++;
      $display("FAIL rst_mid_access: got psel/penable=%b required 11", {psel, penable});
    end
    #2;
    presetn = 1'b0;
    #1;
    total++;
    if ({psel, penable} !== 2'b00) begin
      bad++;
      $display("FAIL rst_mid_drop: got psel/penable=%b required 00", {psel, penable});
    end
    @(posedge pclk); #1;
    presetn   = 1'b1;
    rsp_ready = 1'b1;
    pready    = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge pclk); #1;
      total++;
      if (rsp_valid !== 1'b0 || psel !== 1'b0 || cmd_ready !== 1'b1) begin
        bad++;
        $display("FAIL rst_mid_norsp: got rsp_valid=%b psel=%b cmd_ready=%b required 0/0/1",
                 rsp_valid, psel, cmd_ready);
      end
    end
    rsp_ready = 1'b0;
    pready    = 1'b0;
  endtask

  initial begin
    test_reset();
    test_write_zero_wait();
    test_read_wait3();
    test_slverr();
    test_timeout();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    repeat (2) @(posedge pclk);
    #1;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_empty: got %0d pending required 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
